// File: rtl/trg_out_arb.sv
// Trigger output arbiter: edge-detects, masks and prescales N_SRC sources into one active-low pulse (TRG_SRC_PRIO_EN: one-hot lowest-index tag).
// Latency: trg_out_N falls 2 clk_in cycles after a qualifying source rising edge; tag/vld/busy are registered alongside it.
// No backpressure: qualified requests arriving while busy (or losing priority) are dropped and counted as lost.
module trg_out_arb #(
    parameter int N_SRC     = 4,
    parameter int PRESC_W   = 8,
    parameter int DEAD_W    = 8,
    parameter int CNT_W     = 16,
    parameter int PULSE_LEN = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in_N,
    input  logic                     trg_enb_in,
    input  logic [N_SRC-1:0]         src_trg_in,
    input  logic [N_SRC-1:0]         src_mask_in,
    input  logic [N_SRC*PRESC_W-1:0] presc_in,
    input  logic [DEAD_W-1:0]        dead_time_in,
    input  logic                     daq_busy_in,
    input  logic                     cnt_clr_in,
    output logic                     trg_out_N,
    output logic [N_SRC-1:0]         trg_tag_out,
    output logic                     trg_tag_vld_out,
    output logic                     daq_busy_out,
    output logic [CNT_W-1:0]         eff_trg_cnt_out,
    output logic [CNT_W-1:0]         lost_trg_cnt_out
);

    localparam int PCNT_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [PRESC_W:0] PC_ONE = (PRESC_W+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_DEAD  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [N_SRC-1:0]     src_trg_q, src_trg_d;
    logic [N_SRC-1:0]     qual_q, qual_d;
    logic [PRESC_W-1:0]   pc_q [N_SRC];
    logic [PRESC_W-1:0]   pc_d [N_SRC];
    logic [PCNT_W-1:0]    pcnt_q, pcnt_d;
    logic [DEAD_W-1:0]    dcnt_q, dcnt_d;
    logic [N_SRC-1:0]     tag_q, tag_d;
    logic                 tag_vld_q, tag_vld_d;
    logic                 trg_n_q, trg_n_d;
    logic                 busy_q, busy_d;
    logic [CNT_W-1:0]     eff_q, eff_d;
    logic [CNT_W-1:0]     lost_q, lost_d;

    logic [N_SRC-1:0]     req;
    logic [N_SRC-1:0]     sel;
    logic                 eff_inc;
    logic                 lost_inc;

    assign req       = src_trg_in & ~src_trg_q & ~src_mask_in & {N_SRC{trg_enb_in}};
    assign src_trg_d = src_trg_in;

    // Prescalers run independently of the arbiter so their phase never depends on busy time.
    always_comb begin
        pc_d   = pc_q;
        qual_d = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (req[i]) begin
                if ({1'b0, pc_q[i]} + PC_ONE >= {1'b0, presc_in[i*PRESC_W +: PRESC_W]}) begin
                    qual_d[i] = 1'b1;
                    pc_d[i]   = '0;
                end else begin
                    pc_d[i]   = pc_q[i] + PRESC_W'(1);
                end
            end
            if (cnt_clr_in) begin
                pc_d[i] = '0;
            end
        end
    end

    always_comb begin
        sel = qual_q;
`ifdef TRG_SRC_PRIO_EN
        sel = qual_q & (~qual_q + N_SRC'(1));
`endif
    end

    always_comb begin
        state_d   = state_q;
        pcnt_d    = pcnt_q;
        dcnt_d    = dcnt_q;
        tag_d     = tag_q;
        tag_vld_d = 1'b0;
        eff_inc   = 1'b0;
        lost_inc  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|qual_q) begin
                    tag_d     = sel;
                    tag_vld_d = 1'b1;
                    eff_inc   = 1'b1;
                    pcnt_d    = PCNT_W'(PULSE_LEN - 1);
                    state_d   = S_PULSE;
`ifdef TRG_SRC_PRIO_EN
                    lost_inc  = |(qual_q & ~sel);
`endif
                end
            end
            S_PULSE: begin
                lost_inc = |qual_q;
                if (pcnt_q == '0) begin
                    if (dead_time_in != '0) begin
                        dcnt_d  = dead_time_in - DEAD_W'(1);
                        state_d = S_DEAD;
                    end else begin
                        state_d = daq_busy_in ? S_HOLD : S_IDLE;
                    end
                end else begin
                    pcnt_d = pcnt_q - PCNT_W'(1);
                end
            end
            S_DEAD: begin
                lost_inc = |qual_q;
                if (dcnt_q == '0) begin
                    state_d = daq_busy_in ? S_HOLD : S_IDLE;
                end else begin
                    dcnt_d = dcnt_q - DEAD_W'(1);
                end
            end
            S_HOLD: begin
                lost_inc = |qual_q;
                if (!daq_busy_in) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so pulse, tag and busy share one alignment.
    always_comb begin
        trg_n_d = (state_d != S_PULSE);
        busy_d  = (state_d != S_IDLE);
    end

    always_comb begin
        eff_d  = eff_q;
        lost_d = lost_q;
        if (cnt_clr_in) begin
            eff_d  = '0;
            lost_d = '0;
        end else begin
            if (eff_inc && (eff_q != '1)) begin
                eff_d = eff_q + CNT_W'(1);
            end
            if (lost_inc && (lost_q != '1)) begin
                lost_d = lost_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in_N) begin
        if (!rst_in_N) begin
            state_q   <= S_IDLE;
            src_trg_q <= '0;
            qual_q    <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                pc_q[i] <= '0;
            end
            pcnt_q    <= '0;
            dcnt_q    <= '0;
            tag_q     <= '0;
            tag_vld_q <= 1'b0;
            trg_n_q   <= 1'b1;
            busy_q    <= 1'b0;
            eff_q     <= '0;
            lost_q    <= '0;
        end else begin
            state_q   <= state_d;
            src_trg_q <= src_trg_d;
            qual_q    <= qual_d;
            for (int i = 0; i < N_SRC; i++) begin
                pc_q[i] <= pc_d[i];
            end
            pcnt_q    <= pcnt_d;
            dcnt_q    <= dcnt_d;
            tag_q     <= tag_d;
            tag_vld_q <= tag_vld_d;
            trg_n_q   <= trg_n_d;
            busy_q    <= busy_d;
            eff_q     <= eff_d;
            lost_q    <= lost_d;
        end
    end

    assign trg_out_N        = trg_n_q;
    assign trg_tag_out      = tag_q;
    assign trg_tag_vld_out  = tag_vld_q;
    assign daq_busy_out     = busy_q;
    assign eff_trg_cnt_out  = eff_q;
    assign lost_trg_cnt_out = lost_q;

endmodule

// File: tb/tb_trg_out_arb.sv
// Directed bench for trg_out_arb; a second instance with 2-bit counters exercises counter saturation.
module tb_trg_out_arb;

    localparam int N  = 4;
    localparam int PW = 8;
    localparam int DW = 8;
    localparam int CW = 16;
    localparam int PL = 4;
`ifdef TRG_SRC_PRIO_EN
    localparam int         PRIO_LOST = 1;
    localparam logic [3:0] TAG13     = 4'b0010;
`else
    localparam int         PRIO_LOST = 0;
    localparam logic [3:0] TAG13     = 4'b1010;
`endif

    logic            clk_in = 1'b0;
    logic            rst_in_N;
    logic            trg_enb_in;
    logic [N-1:0]    src_trg_in;
    logic [N-1:0]    src_mask_in;
    logic [N*PW-1:0] presc_in;
    logic [DW-1:0]   dead_time_in;
    logic            daq_busy_in;
    logic            cnt_clr_in;

    logic            trg_out_N;
    logic [N-1:0]    trg_tag_out;
    logic            trg_tag_vld_out;
    logic            daq_busy_out;
    logic [CW-1:0]   eff_trg_cnt_out;
    logic [CW-1:0]   lost_trg_cnt_out;

    logic            s_trg_out_N;
    logic [N-1:0]    s_trg_tag_out;
    logic            s_trg_tag_vld_out;
    logic            s_daq_busy_out;
    logic [1:0]      s_eff;
    logic [1:0]      s_lost;

    int total = 0;
    int bad   = 0;
    int lo_cnt = 0;
    int bz_cnt = 0;
    int vld_cnt = 0;
    int lo0, bz0, vld0;

    always #10 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (!trg_out_N)      lo_cnt++;
        if (daq_busy_out)    bz_cnt++;
        if (trg_tag_vld_out) vld_cnt++;
    end

    trg_out_arb #(.N_SRC(N), .PRESC_W(PW), .DEAD_W(DW), .CNT_W(CW), .PULSE_LEN(PL)) dut (
        .clk_in(clk_in), .rst_in_N(rst_in_N), .trg_enb_in(trg_enb_in),
        .src_trg_in(src_trg_in), .src_mask_in(src_mask_in), .presc_in(presc_in),
        .dead_time_in(dead_time_in), .daq_busy_in(daq_busy_in), .cnt_clr_in(cnt_clr_in),
        .trg_out_N(trg_out_N), .trg_tag_out(trg_tag_out), .trg_tag_vld_out(trg_tag_vld_out),
        .daq_busy_out(daq_busy_out), .eff_trg_cnt_out(eff_trg_cnt_out),
        .lost_trg_cnt_out(lost_trg_cnt_out)
    );

    trg_out_arb #(.N_SRC(N), .PRESC_W(PW), .DEAD_W(DW), .CNT_W(2), .PULSE_LEN(PL)) dut_s (
        .clk_in(clk_in), .rst_in_N(rst_in_N), .trg_enb_in(trg_enb_in),
        .src_trg_in(src_trg_in), .src_mask_in(src_mask_in), .presc_in(presc_in),
        .dead_time_in(dead_time_in), .daq_busy_in(daq_busy_in), .cnt_clr_in(cnt_clr_in),
        .trg_out_N(s_trg_out_N), .trg_tag_out(s_trg_tag_out), .trg_tag_vld_out(s_trg_tag_vld_out),
        .daq_busy_out(s_daq_busy_out), .eff_trg_cnt_out(s_eff),
        .lost_trg_cnt_out(s_lost)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic pulse(input int idx);
        src_trg_in[idx] = 1'b1;
        tick(1);
        src_trg_in[idx] = 1'b0;
    endtask

    task automatic snap();
        lo0  = lo_cnt;
        bz0  = bz_cnt;
        vld0 = vld_cnt;
    endtask

    initial begin
        rst_in_N     = 1'b0;
        trg_enb_in   = 1'b1;
        src_trg_in   = '0;
        src_mask_in  = '0;
        presc_in     = {8'd1, 8'd1, 8'd1, 8'd1};
        dead_time_in = 8'd10;
        daq_busy_in  = 1'b0;
        cnt_clr_in   = 1'b0;
        #35;
        chk("rst_trg_n", 32'(trg_out_N), 32'd1);
        chk("rst_tag",   32'(trg_tag_out), 32'd0);
        chk("rst_vld",   32'(trg_tag_vld_out), 32'd0);
        chk("rst_busy",  32'(daq_busy_out), 32'd0);
        chk("rst_eff",   32'(eff_trg_cnt_out), 32'd0);
        chk("rst_lost",  32'(lost_trg_cnt_out), 32'd0);
        rst_in_N = 1'b1;
        tick(2);

        // single held level on src 2
        snap();
        src_trg_in[2] = 1'b1;
        tick(1);
        chk("t1_lat1_trg_n", 32'(trg_out_N), 32'd1);
        tick(1);
        chk("t1_lat2_trg_n", 32'(trg_out_N), 32'd0);
        chk("t1_vld",        32'(trg_tag_vld_out), 32'd1);
        chk("t1_tag",        32'(trg_tag_out), 32'h4);
        chk("t1_busy",       32'(daq_busy_out), 32'd1);
        tick(1);
        chk("t1_vld_off",    32'(trg_tag_vld_out), 32'd0);
        src_trg_in[2] = 1'b0;
        tick(30);
        chk("t1_low_width",  32'(lo_cnt - lo0), 32'd4);
        chk("t1_busy_width", 32'(bz_cnt - bz0), 32'd14);
        chk("t1_trig_cnt",   32'(vld_cnt - vld0), 32'd1);
        chk("t1_eff",        32'(eff_trg_cnt_out), 32'd1);

        // prescale by 3 on src 0
        presc_in[7:0] = 8'd3;
        snap();
        for (int p = 0; p < 9; p++) begin
            pulse(0);
            tick(39);
        end
        chk("t2_trig_cnt", 32'(vld_cnt - vld0), 32'd3);
        chk("t2_eff",      32'(eff_trg_cnt_out), 32'd4);
        chk("t2_lost",     32'(lost_trg_cnt_out), 32'd0);
        chk("t2_sat_eff",  32'(s_eff), 32'd3);
        presc_in[7:0] = 8'd1;

        // simultaneous src 1 and src 3
        snap();
        src_trg_in = 4'b1010;
        tick(1);
        src_trg_in = 4'b0000;
        tick(1);
        chk("t3_tag",      32'(trg_tag_out), 32'(TAG13));
        chk("t3_vld",      32'(trg_tag_vld_out), 32'd1);
        tick(40);
        chk("t3_trig_cnt", 32'(vld_cnt - vld0), 32'd1);
        chk("t3_eff",      32'(eff_trg_cnt_out), 32'd5);
        chk("t3_lost",     32'(lost_trg_cnt_out), 32'(PRIO_LOST));

        // second request inside dead time
        dead_time_in = 8'd20;
        snap();
        pulse(0);
        tick(7);
        pulse(0);
        tick(50);
        chk("t4_trig_cnt",   32'(vld_cnt - vld0), 32'd1);
        chk("t4_busy_width", 32'(bz_cnt - bz0), 32'd24);
        chk("t4_lost",       32'(lost_trg_cnt_out), 32'(PRIO_LOST + 1));
        chk("t4_eff",        32'(eff_trg_cnt_out), 32'd6);
        dead_time_in = 8'd10;

        // external DAQ busy hold-off
        snap();
        daq_busy_in = 1'b1;
        pulse(0);
        tick(30);
        pulse(2);
        tick(40);
        chk("t5_hold_busy",  32'(daq_busy_out), 32'd1);
        chk("t5_hold_trg_n", 32'(trg_out_N), 32'd1);
        daq_busy_in = 1'b0;
        tick(1);
        chk("t5_idle",       32'(daq_busy_out), 32'd0);
        tick(5);
        chk("t5_trig_cnt",   32'(vld_cnt - vld0), 32'd1);
        chk("t5_lost",       32'(lost_trg_cnt_out), 32'(PRIO_LOST + 2));
        chk("t5_eff",        32'(eff_trg_cnt_out), 32'd7);
        chk("t5_sat_eff",    32'(s_eff), 32'd3);
        chk("t5_sat_lost",   32'(s_lost), 32'(PRIO_LOST + 2));

        // counter clear
        cnt_clr_in = 1'b1;
        tick(1);
        cnt_clr_in = 1'b0;
        chk("clr_eff",    32'(eff_trg_cnt_out), 32'd0);
        chk("clr_lost",   32'(lost_trg_cnt_out), 32'd0);
        chk("clr_s_eff",  32'(s_eff), 32'd0);
        chk("clr_s_lost", 32'(s_lost), 32'd0);

        // clear also restarts the prescalers
        presc_in[7:0] = 8'd2;
        snap();
        pulse(0);
        tick(5);
        cnt_clr_in = 1'b1;
        tick(1);
        cnt_clr_in = 1'b0;
        pulse(0);
        tick(30);
        chk("pc_clr_no_trig", 32'(vld_cnt - vld0), 32'd0);
        pulse(0);
        tick(30);
        chk("pc_clr_trig",    32'(vld_cnt - vld0), 32'd1);
        chk("pc_clr_eff",     32'(eff_trg_cnt_out), 32'd1);
        presc_in[7:0] = 8'd1;

        // masked source and global disable
        snap();
        src_mask_in[0] = 1'b1;
        pulse(0);
        tick(30);
        src_mask_in[0] = 1'b0;
        trg_enb_in = 1'b0;
        pulse(0);
        tick(30);
        trg_enb_in = 1'b1;
        chk("mask_trig_cnt", 32'(vld_cnt - vld0), 32'd0);
        chk("mask_eff",      32'(eff_trg_cnt_out), 32'd1);
        chk("mask_lost",     32'(lost_trg_cnt_out), 32'd0);

        // asynchronous reset during the pulse
        pulse(1);
        tick(1);
        chk("pre_rst_trg_n", 32'(trg_out_N), 32'd0);
        #3;
        rst_in_N = 1'b0;
        #1;
        chk("async_rst_trg_n", 32'(trg_out_N), 32'd1);
        chk("async_rst_busy",  32'(daq_busy_out), 32'd0);
        chk("async_rst_eff",   32'(eff_trg_cnt_out), 32'd0);
        #5;
        rst_in_N = 1'b1;
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
